// File: rtl/fft_bin_scanner.sv
// Scans a bin window of the trigger FFT output RAM after each frame,
// tracks the peak magnitude bin and pulses trigger on a qualifying streak.
module fft_bin_scanner #(
  parameter int BIN_LO        = 1,
  parameter int BIN_HI        = 31,
  parameter int TARGET_BIN    = 10,
  parameter int BIN_TOL       = 1,
  parameter int THRESHOLD     = 100,
  parameter int CONSEC_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       send_frame,
  input  logic       fft_output_RAM_ready,
  input  logic [9:0] fft_output_RAM_data,
  output logic [5:0] fft_output_RAM_addr,
  output logic       scan_done,
  output logic [5:0] peak_bin,
  output logic [8:0] peak_mag,
  output logic       trigger
);

  typedef enum logic [2:0] {
    IDLE, WAIT_WR, WAIT_DONE, SCAN, FLUSH, DECIDE
  } state_t;

  localparam logic [5:0] LO = 6'(BIN_LO);
  localparam logic [5:0] HI = 6'(BIN_HI);

  state_t     state_q, state_d;
  logic [5:0] addr_q, addr_d;
  logic       rd_vld_q, rd_vld_d;
  logic [5:0] rd_bin_q, rd_bin_d;
  logic [8:0] max_mag_q, max_mag_d;
  logic [5:0] max_bin_q, max_bin_d;
  logic [8:0] peak_mag_q, peak_mag_d;
  logic [5:0] peak_bin_q, peak_bin_d;
  logic       scan_done_q, scan_done_d;
  logic       trigger_q, trigger_d;
  logic [3:0] streak_q, streak_d;

  logic [9:0] neg;
  logic [8:0] mag;
  logic [3:0] streak_inc;
  logic       qual;

  // |data| with -512 saturated into the 9-bit range
  always_comb begin
    neg = 10'(~fft_output_RAM_data + 10'd1);
    if (fft_output_RAM_data == 10'h200) mag = 9'd511;
    else if (fft_output_RAM_data[9]) mag = neg[8:0];
    else mag = fft_output_RAM_data[8:0];
  end

  always_comb begin
    streak_inc = streak_q + 4'd1;
    qual = (max_mag_q >= 9'(THRESHOLD))
        && (int'(max_bin_q) + BIN_TOL >= TARGET_BIN)
        && (int'(max_bin_q) <= TARGET_BIN + BIN_TOL);
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rd_vld_d    = 1'b0;
    rd_bin_d    = rd_bin_q;
    max_mag_d   = max_mag_q;
    max_bin_d   = max_bin_q;
    peak_mag_d  = peak_mag_q;
    peak_bin_d  = peak_bin_q;
    scan_done_d = 1'b0;
    trigger_d   = 1'b0;
    streak_d    = streak_q;

    if (rd_vld_q && (mag > max_mag_q)) begin
      max_mag_d = mag;
      max_bin_d = rd_bin_q;
    end

    unique case (state_q)
      IDLE: begin
        if (send_frame) state_d = WAIT_WR;
      end
      WAIT_WR: begin
        if (!fft_output_RAM_ready) begin
          state_d = WAIT_DONE;
          addr_d  = LO;
        end
      end
      WAIT_DONE: begin
        if (fft_output_RAM_ready) begin
          state_d   = SCAN;
          max_mag_d = 9'd0;
          max_bin_d = LO;
        end
      end
      SCAN: begin
        if (!fft_output_RAM_ready) begin
          state_d = WAIT_DONE;
          addr_d  = LO;
        end else begin
          rd_vld_d = 1'b1;
          rd_bin_d = addr_q;
          if (addr_q == HI) state_d = FLUSH;
          else addr_d = addr_q + 6'd1;
        end
      end
      FLUSH: begin
        if (!fft_output_RAM_ready) begin
          state_d = WAIT_DONE;
          addr_d  = LO;
        end else begin
          state_d = DECIDE;
        end
      end
      DECIDE: begin
        state_d     = IDLE;
        peak_mag_d  = max_mag_q;
        peak_bin_d  = max_bin_q;
        scan_done_d = 1'b1;
        if (!qual) begin
          streak_d = 4'd0;
        end else if (streak_inc == 4'(CONSEC_FRAMES)) begin
          streak_d  = 4'd0;
          trigger_d = 1'b1;
        end else begin
          streak_d = streak_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    // disable aborts everything but leaves the last result visible
    if (!enable) begin
      state_d     = IDLE;
      addr_d      = addr_q;
      rd_vld_d    = 1'b0;
      peak_mag_d  = peak_mag_q;
      peak_bin_d  = peak_bin_q;
      scan_done_d = 1'b0;
      trigger_d   = 1'b0;
      streak_d    = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= 6'd0;
      rd_vld_q    <= 1'b0;
      rd_bin_q    <= 6'd0;
      max_mag_q   <= 9'd0;
      max_bin_q   <= 6'd0;
      peak_mag_q  <= 9'd0;
      peak_bin_q  <= 6'd0;
      scan_done_q <= 1'b0;
      trigger_q   <= 1'b0;
      streak_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_vld_q    <= rd_vld_d;
      rd_bin_q    <= rd_bin_d;
      max_mag_q   <= max_mag_d;
      max_bin_q   <= max_bin_d;
      peak_mag_q  <= peak_mag_d;
      peak_bin_q  <= peak_bin_d;
      scan_done_q <= scan_done_d;
      trigger_q   <= trigger_d;
      streak_q    <= streak_d;
    end
  end

  assign fft_output_RAM_addr = addr_q;
  assign scan_done           = scan_done_q;
  assign peak_bin            = peak_bin_q;
  assign peak_mag            = peak_mag_q;
  assign trigger             = trigger_q;

endmodule

// File: tb/tb_fft_bin_scanner.sv
// Directed bench for fft_bin_scanner with a 1-cycle-latency RAM model.
module tb_fft_bin_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       send_frame;
  logic       ready;
  logic [9:0] rdata;
  logic [5:0] addr;
  logic       scan_done;
  logic [5:0] peak_bin;
  logic [8:0] peak_mag;
  logic       trigger;

  logic [9:0] ram [64];
  int checks = 0;
  int errors = 0;
  int max_addr = 0;

  fft_bin_scanner dut (
    .clk                  (clk),
    .reset                (reset),
    .enable               (enable),
    .send_frame           (send_frame),
    .fft_output_RAM_ready (ready),
    .fft_output_RAM_data  (rdata),
    .fft_output_RAM_addr  (addr),
    .scan_done            (scan_done),
    .peak_bin             (peak_bin),
    .peak_mag             (peak_mag),
    .trigger              (trigger)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rdata <= ram[addr];

  always @(posedge clk)
    if (!reset && int'(addr) > max_addr) max_addr <= int'(addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ram(input int b1, input logic [9:0] v1,
                          input int b2, input logic [9:0] v2);
    for (int i = 0; i < 64; i++) ram[i] = 10'd5;
    ram[b1] = v1;
    ram[b2] = v2;
  endtask

  task automatic start_frame();
    send_frame = 1'b1;
    tick();
    send_frame = 1'b0;
    ready = 1'b0;
    repeat (64) tick();
  endtask

  // releases ready, then watches a fixed window for scan_done pulses
  task automatic finish_frame(output int n, output int lat,
                              output bit trg);
    n = 0; lat = -1; trg = 1'b0;
    ready = 1'b1;
    tick();
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (scan_done) begin
        if (n == 0) begin lat = i; trg = trigger; end
        n++;
      end
    end
  endtask

  task automatic do_frame(input string nm, input int e_bin,
                          input int e_mag, input bit e_trg);
    int n, lat;
    bit trg;
    start_frame();
    finish_frame(n, lat, trg);
    checks++;
    if (n !== 1 || lat !== 33) begin
      errors++;
      $display("FAIL %s_latency got n=%0d lat=%0d want n=1 lat=33",
               nm, n, lat);
    end
    checks++;
    if (int'(peak_bin) !== e_bin || int'(peak_mag) !== e_mag) begin
      errors++;
      $display("FAIL %s_peak got %0d/%0d want %0d/%0d",
               nm, peak_bin, peak_mag, e_bin, e_mag);
    end
    checks++;
    if (trg !== e_trg) begin
      errors++;
      $display("FAIL %s_trigger got %0b want %0b", nm, trg, e_trg);
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1; enable = 1'b1; send_frame = 1'b0; ready = 1'b1;
    load_ram(10, 10'd5, 10, 10'd5);
    repeat (3) tick();
    checks++;
    if ({addr, scan_done, peak_bin, peak_mag, trigger} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
               {addr, scan_done, peak_bin, peak_mag, trigger});
    end
    reset = 1'b0;
    n = 0;
    repeat (200) begin tick(); if (scan_done) n++; end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL idle_no_scan got %0d want 0", n);
    end
  endtask

  task automatic test_single_peak();
    load_ram(10, 10'd300, 10, 10'd300);
    do_frame("single", 10, 300, 1'b0);
    checks++;
    if (addr !== 6'd31) begin
      errors++;
      $display("FAIL addr_hold got %0d want 31", addr);
    end
  endtask

  task automatic test_streak();
    do_frame("streak2", 10, 300, 1'b1);
    do_frame("streak3", 10, 300, 1'b0);
    load_ram(20, 10'd300, 20, 10'd300);
    do_frame("offbin", 20, 300, 1'b0);
    load_ram(10, 10'd300, 10, 10'd300);
    do_frame("re1", 10, 300, 1'b0);
    do_frame("re2", 10, 300, 1'b1);
  endtask

  task automatic test_arith();
    load_ram(9, 10'h1FF, 11, 10'h200);
    do_frame("tie", 9, 511, 1'b0);
    load_ram(10, 10'd99, 10, 10'd99);
    do_frame("below_thr", 10, 99, 1'b0);
    load_ram(10, 10'd100, 10, 10'd100);
    do_frame("at_thr", 10, 100, 1'b0);
  endtask

  task automatic test_abort();
    int n, lat;
    bit trg;
    load_ram(10, 10'd300, 10, 10'd300);
    start_frame();
    ready = 1'b1;
    tick();
    repeat (9) tick();
    ready = 1'b0;
    n = 0;
    repeat (20) begin tick(); if (scan_done) n++; end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d want 0", n);
    end
    load_ram(11, 10'd250, 11, 10'd250);
    finish_frame(n, lat, trg);
    checks++;
    if (n !== 1 || lat !== 33) begin
      errors++;
      $display("FAIL rescan_latency got n=%0d lat=%0d want 1/33", n, lat);
    end
    checks++;
    if (peak_bin !== 6'd11 || peak_mag !== 9'd250 || trg !== 1'b1) begin
      errors++;
      $display("FAIL rescan_result got %0d/%0d/%0b want 11/250/1",
               peak_bin, peak_mag, trg);
    end
  endtask

  task automatic test_enable_drop();
    int n;
    load_ram(10, 10'd300, 10, 10'd300);
    do_frame("pre_en", 10, 300, 1'b0);
    start_frame();
    ready = 1'b1;
    tick();
    repeat (9) tick();
    enable = 1'b0;
    n = 0;
    repeat (50) begin tick(); if (scan_done || trigger) n++; end
    checks++;
    if (n !== 0 || peak_bin !== 6'd10 || peak_mag !== 9'd300) begin
      errors++;
      $display("FAIL enable_drop got n=%0d %0d/%0d want 0 10/300",
               n, peak_bin, peak_mag);
    end
    enable = 1'b1;
    do_frame("post_en", 10, 300, 1'b0);
  endtask

  task automatic test_reset_mid();
    int n;
    start_frame();
    ready = 1'b1;
    tick();
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({addr, scan_done, peak_bin, peak_mag, trigger} !== 23'd0) begin
      errors++;
      $display("FAIL reset_mid got %h want 0",
               {addr, scan_done, peak_bin, peak_mag, trigger});
    end
    n = 0;
    repeat (50) begin tick(); if (scan_done) n++; end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done got %0d want 0", n);
    end
    do_frame("post_rst", 10, 300, 1'b0);
    checks++;
    if (max_addr > 31) begin
      errors++;
      $display("FAIL addr_bound got %0d want <=31", max_addr);
    end
  endtask

  initial begin
    test_reset();
    test_single_peak();
    test_streak();
    test_arith();
    test_abort();
    test_enable_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_bin_scanner.md
Name: fft_bin_scanner

Overview:
Reader for the trigger FFT output RAM (10-bit x 64, read port). After each FFT output frame is fully written, scans a bin window, finds the peak magnitude bin and decides whether the frame qualifies as a ping. Asserts a one-cycle trigger after CONSEC_FRAMES consecutive qualifying frames. Sits between the trigger FFT and the top-level capture/trigger logic.

Parameters:
BIN_LO, 1, first bin scanned (inclusive); 0 excluded as DC
BIN_HI, 31, last bin scanned (inclusive); must satisfy BIN_LO <= BIN_HI <= 63
TARGET_BIN, 10, expected pinger bin
BIN_TOL, 1, allowed |peak_bin - TARGET_BIN|
THRESHOLD, 100, minimum peak magnitude (unsigned, 0..511)
CONSEC_FRAMES, 2, qualifying frames in a row needed to trigger (1..15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  scanner enable; low forces IDLE and clears streak
send_frame  in  1  pulse: FFT controller sent a frame into the FFT
fft_output_RAM_ready  in  1  high when the FFT is not writing the RAM
fft_output_RAM_data  in  10  RAM read data, signed two's complement real part
fft_output_RAM_addr  out  6  RAM read address
scan_done  out  1  one-cycle pulse: scan result valid
peak_bin  out  6  bin of max magnitude in last completed scan
peak_mag  out  9  max magnitude in last completed scan
trigger  out  1  one-cycle pulse on qualifying streak completion

Behaviour:
- Reset: all outputs 0, state IDLE, streak counter 0, fft_output_RAM_addr 0.
- All logic on rising clk; reset has priority over enable, enable over everything else.
- RAM read latency fixed at 1 cycle: address presented in cycle N, data sampled in cycle N+1.
- Magnitude = |data|; -512 saturates to 511; result 9 bits unsigned.
- States:
  - IDLE: wait for send_frame while enable=1 -> WAIT_WR.
  - WAIT_WR: wait for fft_output_RAM_ready=0 (write started) -> WAIT_DONE.
  - WAIT_DONE: wait for fft_output_RAM_ready=1 -> SCAN; addr loaded with BIN_LO on entry.
  - SCAN: addr increments each cycle BIN_LO..BIN_HI; data sampled one cycle behind; after issuing BIN_HI -> FLUSH.
  - FLUSH: sample last bin (BIN_HI) -> DECIDE.
  - DECIDE: update peak_bin/peak_mag, pulse scan_done, update streak, optional trigger -> IDLE.
- Peak tracking: running max with strict greater-than; ties keep the lower bin. Running max starts at 0/BIN_LO each scan.
- peak_bin/peak_mag hold their value between scans; updated only in DECIDE.
- Qualifying frame: peak_mag >= THRESHOLD and |peak_bin - TARGET_BIN| <= BIN_TOL (signed compare, no wrap).
- Streak: qualifying -> streak+1; non-qualifying -> 0. When streak+1 reaches CONSEC_FRAMES: trigger=1 same cycle as scan_done, streak reset to 0.
- Scan latency: scan_done exactly (BIN_HI-BIN_LO+3) cycles after entering SCAN.
- Boundary cases:
  - fft_output_RAM_ready falls during SCAN or FLUSH (new write overlapping): abort, discard partial result, no scan_done, streak unchanged, -> WAIT_DONE (rescan after write completes).
  - send_frame while not IDLE: ignored.
  - send_frame and ready=0 in same IDLE cycle: go to WAIT_WR; ready=0 seen next cycle advances normally.
  - enable drops mid-scan: next cycle IDLE, streak 0, outputs hold, no pulses.
  - BIN_LO = BIN_HI: single-bin scan, scan_done 3 cycles after SCAN entry.
  - Reset mid-scan: all state/outputs to reset values next cycle.
- fft_output_RAM_addr outside SCAN holds last value; never drives address > BIN_HI.

Test Plan:
- Reset/idle: assert reset 3 cycles -> all outputs 0; no send_frame -> no scan_done for 200 cycles.
- Single peak: RAM bin 10 = +300, others +5; send_frame, ready low 64 cycles then high -> scan_done 33 cycles after SCAN entry, peak_bin=10, peak_mag=300, trigger=0 (streak 1 of 2).
- Streak trigger: repeat frame twice -> second scan_done with trigger=1; third qualifying frame -> trigger=0 (streak restarted); interleave non-qualifying frame (peak bin 20) -> streak cleared, trigger needs two more.
- Arithmetic edges: bin 11 = -512, bin 9 = 511 -> peak_mag=511, peak_bin=9 (tie, lower bin); THRESHOLD-1 peak -> not qualifying.
- Abort: drop ready at 10th SCAN cycle -> no scan_done, rescan after ready returns, single scan_done with correct result.
- enable low / reset mid-scan -> IDLE next cycle, no scan_done, streak 0.
